// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 scan-code constants, decoder state encoding and event layout.
package ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;

  // Bytes after the E1 prefix that belong to the Pause sequence.
  localparam int unsigned PAUSE_TAIL = 7;

  localparam int unsigned EV_W = 10;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_PAUSE
  } dec_state_t;

  // Keyboard status/ack/error bytes that never form a key event.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default:                                         is_ignored = 1'b0;
    endcase
  endfunction

  function automatic ps2_event_t pack_ev(input logic rel, input logic ext,
                                         input logic [7:0] code);
    ps2_event_t e;
    e.rel  = rel;
    e.ext  = ext;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; a write becomes visible to the
// read side one cycle after it lands.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_vis;
  logic             rd_fire;
  logic             wr_fire;

  // Full uses the live write pointer; emptiness uses the lagged copy so a
  // push into an empty FIFO only shows on the following cycle.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = (rd_ptr != wr_ptr_vis);
  assign rd_data  = mem[rd_ptr[AW-1:0]];
  assign rd_fire  = rd_en && rd_valid;
  assign wr_fire  = wr_en && (!full || rd_fire);

  // Pointer bookkeeping
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_ptr_vis <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      wr_ptr_vis <= wr_ptr;
    end
  end

  // Storage write
  always_ff @(posedge clk_50) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns a stream of PS/2 Set-2 bytes into make/break key events queued in a FIFO.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       overflow,
  output logic       timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] SKIP_LAST = 3'(PAUSE_TAIL - 1);

  dec_state_t    state_q, state_d;
  logic          ext_q, ext_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tmo_d;
  logic          push_q, push_d;
  ps2_event_t    ev_q, ev_d;
  logic          in_valid_q;
  logic          accept;

  logic             fifo_full;
  logic [EV_W-1:0]  fifo_rd_data;
  ps2_event_t       head;

  assign accept = in_valid && !in_valid_q;

  // Edge history, FSM registers and the registered push request
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      in_valid_q  <= 1'b1;
      state_q     <= ST_IDLE;
      ext_q       <= 1'b0;
      skip_q      <= '0;
      tcnt_q      <= '0;
      timeout_err <= 1'b0;
      push_q      <= 1'b0;
      ev_q        <= '0;
    end else begin
      in_valid_q  <= in_valid;
      state_q     <= state_d;
      ext_q       <= ext_d;
      skip_q      <= skip_d;
      tcnt_q      <= tcnt_d;
      timeout_err <= tmo_d;
      push_q      <= push_d;
      ev_q        <= ev_d;
    end
  end

  // Decode next state, prefix tracking, event generation and prefix timeout
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    skip_d  = skip_q;
    tcnt_d  = tcnt_q;
    tmo_d   = 1'b0;
    push_d  = 1'b0;
    ev_d    = '0;
    if (accept) begin
      tcnt_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_data == SC_E0) begin
            state_d = ST_GOT_E0;
          end else if (in_data == SC_F0) begin
            state_d = ST_GOT_F0;
            ext_d   = 1'b0;
          end else if (in_data == SC_E1) begin
            state_d = ST_PAUSE;
            skip_d  = '0;
          end else if (!is_ignored(in_data)) begin
            push_d = 1'b1;
            ev_d   = pack_ev(1'b0, 1'b0, in_data);
          end
        end
        ST_GOT_E0: begin
          if (in_data == SC_F0) begin
            state_d = ST_GOT_F0;
            ext_d   = 1'b1;
          end else if (in_data != SC_E0) begin
            push_d  = 1'b1;
            ev_d    = pack_ev(1'b0, 1'b1, in_data);
            state_d = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          push_d  = 1'b1;
          ev_d    = pack_ev(1'b1, ext_q, in_data);
          state_d = ST_IDLE;
          ext_d   = 1'b0;
        end
        ST_PAUSE: begin
          if (skip_q == SKIP_LAST) begin
            push_d  = 1'b1;
            ev_d    = pack_ev(1'b0, 1'b0, SC_E1);
            state_d = ST_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q + 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tcnt_q == TMO_LAST) begin
        state_d = ST_IDLE;
        ext_d   = 1'b0;
        skip_d  = '0;
        tcnt_d  = '0;
        tmo_d   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = '0;
    end
  end

  // Sticky flag: event lost because the queue had no room this cycle
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push_q && fifo_full && !(ev_valid && ev_ready)) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(EV_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .wr_en   (push_q),
    .wr_data (ev_q),
    .rd_en   (ev_ready),
    .rd_valid(ev_valid),
    .rd_data (fifo_rd_data),
    .full    (fifo_full)
  );

  assign head       = ps2_event_t'(fifo_rd_data);
  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_release = head.rel;

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of 2, >=2).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2_500_000, meaning idle clk_50 cycles (50 ms) before an incomplete prefix sequence is abandoned.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low; ports are clk_50 (input, 1) and reset_n (input, 1).
REQ-004 in_valid  input  1  level from PS/2 byte receiver, high while in_data holds a checked byte.
REQ-005 in_data  input  8  received Set-2 scan code byte.
REQ-006 ev_valid  output  1  FIFO head holds an event.
REQ-007 ev_ready  input  1  consumer accepts head when ev_valid && ev_ready at a clk_50 edge.
REQ-008 ev_code  output  8  key code of head event (0xE1 for Pause).
REQ-009 ev_ext  output  1  head event was E0-prefixed.
REQ-010 ev_release  output  1  head event is a break (key up).
REQ-011 overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-012 timeout_err  output  1  one-cycle pulse when a prefix sequence is abandoned.

Function
REQ-013 A byte SHALL be accepted only on the cycle where in_valid is sampled high and was low on the previous edge; a held-high in_valid SHALL yield exactly one byte.
REQ-014 Decode FSM states SHALL be IDLE, GOT_E0, GOT_F0, PAUSE; an ext flag register records E0 prefix.
REQ-015 IDLE: 0xE0 -> GOT_E0; 0xF0 -> GOT_F0 with ext=0; 0xE1 -> PAUSE with skip counter=0; 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF -> dropped, stay IDLE; any other byte -> push make event {code, ext=0, release=0}.
REQ-016 GOT_E0: 0xF0 -> GOT_F0 with ext=1; 0xE0 -> stay GOT_E0; any other byte -> push make {code, ext=1, release=0}, -> IDLE.
REQ-017 GOT_F0: any byte -> push break {code, ext, release=1}, -> IDLE, ext cleared.
REQ-018 PAUSE: SHALL consume exactly 7 further bytes regardless of value; on the 7th, push {0xE1, ext=0, release=0} and return to IDLE.
REQ-019 Event push SHALL occur on the edge after byte acceptance; ev_valid SHALL rise the cycle after the push into an empty FIFO (accepted byte edge k -> ev_valid high after edge k+2).
REQ-020 In any state other than IDLE, a timeout counter SHALL count cycles without an accepted byte; on reaching TIMEOUT_CYCLES the FSM SHALL return to IDLE, clear ext and skip counter, and pulse timeout_err for one cycle; the counter SHALL reset on every accepted byte and in IDLE.
REQ-021 FIFO: first-word fall-through; head fields stable while ev_valid && !ev_ready.
REQ-022 Push while full without a same-cycle pop SHALL drop the new event and set overflow; push and pop in the same cycle while full SHALL both succeed.
REQ-023 Push and pop in the same cycle while empty SHALL not occur (ev_valid low); push into empty SHALL not be visible on the same cycle.
REQ-024 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full = MSBs differ and low bits equal.

Reset
REQ-025 While reset_n is low at a clk_50 edge: FSM=IDLE, ext=0, skip and timeout counters=0, FIFO empty, ev_valid=0, overflow=0, timeout_err=0, in_valid edge-history register=1 (a byte held across reset release is not re-accepted).
REQ-026 Reset mid-sequence SHALL discard any partial prefix and all queued events.

Structure
REQ-027 A shared package ps2_pkg SHALL hold scan-code constants (E0, F0, E1, ignored codes) and the event field layout (10 bits: release, ext, code).
REQ-028 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH); decode FSM and timeout stay in ps2_scancode_decoder.

Verification
REQ-029 Bytes 0x1C, 0xF0, 0x1C with ev_ready=1 -> events {1C,ext0,rel0} then {1C,ext0,rel1}.
REQ-030 Bytes E0, F0, 75 -> single event {75,ext1,rel1}; bytes E0, 75 -> {75,ext1,rel0}.
REQ-031 Bytes E1,14,77,E1,F0,14,F0,77 -> exactly one event {E1,0,0}; 0xAA and 0xFA alone -> no event.
REQ-032 ev_ready=0, 5 make codes with FIFO_DEPTH=4 -> 4 events held in order, overflow=1 after 5th; then ev_ready=1 drains 4, ev_valid low.
REQ-033 Byte E0 then no input for TIMEOUT_CYCLES (set 100) -> timeout_err pulse at cycle 100; next byte 0x1C -> {1C,ext0,rel0}.
REQ-034 in_valid held high 1000 cycles with 0x1C -> one event only; reset_n low after F0 -> next 0x1C yields make, not break.
